// File: rtl/dnn_argmax_scorer_pkg.sv
// +--------------------------------------------------------------------+
// | dnn_pkg : shared constants, score-array type and scorer FSM states |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package dnn_pkg;

  localparam int N_CLASSES = 10;
  localparam int FIX8_W    = 8;
  localparam int IDX_W     = 4;

  typedef logic [N_CLASSES-1:0][FIX8_W-1:0] score_arr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scorer_state_t;

endpackage

`default_nettype wire

// File: rtl/dnn_argmax_scorer_sat_counter.sv
// +--------------------------------------------------------------------+
// | sat_counter : up-counter with sync clear that sticks at all-ones   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;

  // clear takes priority over a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/dnn_argmax_scorer.sv
// +--------------------------------------------------------------------+
// | dnn_argmax_scorer : sequential argmax over class scores, hit stats |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dnn_argmax_scorer
  import dnn_pkg::*;
#(
  parameter int N_CLASSES  = dnn_pkg::N_CLASSES,
  parameter int DATA_WIDTH = dnn_pkg::FIX8_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] scores,
  input  logic [3:0]                           exp_y,
  input  logic                                 clear,
  output logic                                 busy,
  output logic                                 done,
  output logic [3:0]                           pred_idx,
  output logic signed [DATA_WIDTH-1:0]         pred_conf,
  output logic                                 hit,
  output logic [CNT_WIDTH-1:0]                 hit_count,
  output logic [CNT_WIDTH-1:0]                 test_count
);

  scorer_state_t                        state_q, state_d;
  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] scores_q;
  logic [IDX_W-1:0]                     exp_q, scan_q, run_idx_q, run_idx_d, pred_idx_q;
  logic signed [DATA_WIDTH-1:0]         run_max_q, run_max_d, pred_conf_q, cur_score;
  logic                                 hit_q, last, finish, finish_hit;

  always_comb begin
    cur_score  = $signed(scores_q[scan_q]);
    run_max_d  = run_max_q;
    run_idx_d  = run_idx_q;
    // running max starts at 0, so only strictly positive scores can win
    if (cur_score > run_max_q) begin
      run_max_d = cur_score;
      run_idx_d = scan_q + IDX_W'(1);
    end
    last       = (scan_q == IDX_W'(N_CLASSES-1));
    finish     = (state_q == SCAN) && last;
    finish_hit = (run_idx_d == exp_q);

    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scores_q    <= '0;
      exp_q       <= '0;
      scan_q      <= '0;
      run_idx_q   <= '0;
      run_max_q   <= '0;
      pred_idx_q  <= '0;
      pred_conf_q <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        scores_q  <= scores;
        exp_q     <= exp_y;
        scan_q    <= '0;
        run_idx_q <= '0;
        run_max_q <= '0;
      end else if (state_q == SCAN) begin
        scan_q    <= scan_q + IDX_W'(1);
        run_idx_q <= run_idx_d;
        run_max_q <= run_max_d;
        if (finish) begin
          pred_idx_q  <= run_idx_d;
          pred_conf_q <= run_max_d;
          hit_q       <= finish_hit;
        end
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (finish && finish_hit),
    .clr_i   (clear),
    .count_o (hit_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_test_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (finish),
    .clr_i   (clear),
    .count_o (test_count)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pred_idx  = pred_idx_q;
  assign pred_conf = pred_conf_q;
  assign hit       = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_dnn_argmax_scorer.sv
// +--------------------------------------------------------------------+
// | tb_dnn_argmax_scorer : directed self-checking bench for the scorer |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dnn_argmax_scorer;
  import dnn_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, start_s = 1'b0;
  logic             clear = 1'b0, clear_s = 1'b0;
  score_arr_t       scores = '0;
  logic [3:0]       exp_y = '0;

  logic             busy, done, hit;
  logic [3:0]       pred_idx;
  logic signed [7:0] pred_conf;
  logic [15:0]      hit_count, test_count;

  logic             busy_s, done_s, hit_s;
  logic [3:0]       pred_idx_s;
  logic signed [7:0] pred_conf_s;
  logic [1:0]       hit_count_s, test_count_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dnn_argmax_scorer u_dut (
    .clk(clk), .rst(rst), .start(start), .scores(scores), .exp_y(exp_y),
    .clear(clear), .busy(busy), .done(done), .pred_idx(pred_idx),
    .pred_conf(pred_conf), .hit(hit), .hit_count(hit_count), .test_count(test_count)
  );

  dnn_argmax_scorer #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .scores(scores), .exp_y(exp_y),
    .clear(clear_s), .busy(busy_s), .done(done_s), .pred_idx(pred_idx_s),
    .pred_conf(pred_conf_s), .hit(hit_s), .hit_count(hit_count_s),
    .test_count(test_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? done_s : done;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy_s : busy;
  endfunction

  task automatic set_ctl(input bit sel, input logic st, input logic cl);
    if (sel) begin start_s = st; clear_s = cl; end
    else     begin start   = st; clear   = cl; end
  endtask

  // Start one inference, scramble the inputs after capture, wait for done.
  task automatic run_infer(input bit sel, input bit nowait, input score_arr_t sc,
                           input logic [3:0] ey, input int restart_at, input int clear_at);
    int cyc;
    if (!nowait) @(negedge clk);
    scores = sc;
    exp_y  = ey;
    set_ctl(sel, 1'b1, 1'b0);
    @(negedge clk);
    set_ctl(sel, 1'b0, 1'b0);
    scores = ~sc;
    exp_y  = ey ^ 4'hF;
    cyc = 0;
    while (cyc < 40) begin
      if (get_done(sel)) break;
      if (cyc == 5) check("busy_in_scan", 32'(get_busy(sel)), 32'd1);
      set_ctl(sel, cyc == restart_at, cyc == clear_at);
      @(negedge clk);
      cyc++;
    end
    set_ctl(sel, 1'b0, 1'b0);
    check("latency", cyc, 32'd10);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    score_arr_t v;
    int n;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pred_idx", 32'(pred_idx), 32'd0);
    check("rst_pred_conf", 32'(pred_conf), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_test_count", 32'(test_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single positive winner at index 3 -> class 4
    v = '0; v[0] = 8'd5; v[3] = 8'd40; v[7] = 8'd12;
    run_infer(1'b0, 1'b0, v, 4'd4, -1, -1);
    check("t1_idx", 32'(pred_idx), 32'd4);
    check("t1_conf", 32'(pred_conf), 32'd40);
    check("t1_hit", 32'(hit), 32'd1);
    check("t1_hc", 32'(hit_count), 32'd1);
    check("t1_tc", 32'(test_count), 32'd1);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_idx_hold", 32'(pred_idx), 32'd4);

    // all negative: no winner
    v = {10{8'hFD}};
    run_infer(1'b0, 1'b0, v, 4'd1, -1, -1);
    check("t2_idx", 32'(pred_idx), 32'd0);
    check("t2_conf", 32'(pred_conf), 32'd0);
    check("t2_hit", 32'(hit), 32'd0);
    check("t2_hc", 32'(hit_count), 32'd1);
    check("t2_tc", 32'(test_count), 32'd2);

    // tie between index 2 and 6 keeps the lower one
    v = {10{8'd1}}; v[2] = 8'd100; v[6] = 8'd100;
    run_infer(1'b0, 1'b0, v, 4'd7, -1, -1);
    check("t3_idx", 32'(pred_idx), 32'd3);
    check("t3_conf", 32'(pred_conf), 32'd100);
    check("t3_hit", 32'(hit), 32'd0);
    check("t3_tc", 32'(test_count), 32'd3);

    // extreme values, second start mid-scan is ignored
    v = '0; v[9] = 8'h7F; v[0] = 8'h80;
    run_infer(1'b0, 1'b0, v, 4'd10, 4, -1);
    check("t4_idx", 32'(pred_idx), 32'd10);
    check("t4_conf", 32'(pred_conf), 32'd127);
    check("t4_hit", 32'(hit), 32'd1);
    check("t4_hc", 32'(hit_count), 32'd2);
    check("t4_tc", 32'(test_count), 32'd4);
    count_dones(15, n);
    check("t4_extra_done", n, 32'd0);
    check("t4_tc_after", 32'(test_count), 32'd4);

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    v = '0; v[1] = 8'd9;
    scores = v; exp_y = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_pred_idx", 32'(pred_idx), 32'd0);
    check("t5_pred_conf", 32'(pred_conf), 32'd0);
    check("t5_hit", 32'(hit), 32'd0);
    check("t5_hc", 32'(hit_count), 32'd0);
    check("t5_tc", 32'(test_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(15, n);
    check("t5_no_done", n, 32'd0);

    // start on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    v = '0; v[0] = 8'd5; v[3] = 8'd40; v[7] = 8'd12;
    run_infer(1'b0, 1'b1, v, 4'd4, -1, -1);
    check("t6_idx", 32'(pred_idx), 32'd4);
    check("t6_tc", 32'(test_count), 32'd1);
    check("t6_hc", 32'(hit_count), 32'd1);

    // clear while idle keeps the last result
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("t7_hc", 32'(hit_count), 32'd0);
    check("t7_tc", 32'(test_count), 32'd0);
    check("t7_idx_kept", 32'(pred_idx), 32'd4);
    check("t7_hit_kept", 32'(hit), 32'd1);

    // clear mid-scan does not abort the scan
    v = {10{8'd1}}; v[2] = 8'd100; v[6] = 8'd100;
    run_infer(1'b0, 1'b0, v, 4'd3, 3, -1 + 0);
    check("t8_idx", 32'(pred_idx), 32'd3);
    check("t8_hit", 32'(hit), 32'd1);
    check("t8_tc", 32'(test_count), 32'd1);
    run_infer(1'b0, 1'b0, v, 4'd7, -1, 3);
    check("t8c_idx", 32'(pred_idx), 32'd3);
    check("t8c_tc", 32'(test_count), 32'd1);
    check("t8c_hc", 32'(hit_count), 32'd0);

    // 2-bit counters saturate, then clear coincident with done wins
    v = '0; v[0] = 8'd5; v[3] = 8'd40; v[7] = 8'd12;
    for (int i = 0; i < 4; i++) run_infer(1'b1, 1'b0, v, 4'd4, -1, -1);
    check("t9_hc_sat", 32'(hit_count_s), 32'd3);
    check("t9_tc_sat", 32'(test_count_s), 32'd3);
    run_infer(1'b1, 1'b0, v, 4'd4, -1, 9);
    check("t9_done", 32'(done_s), 32'd1);
    check("t9_idx", 32'(pred_idx_s), 32'd4);
    check("t9_hc_clr", 32'(hit_count_s), 32'd0);
    check("t9_tc_clr", 32'(test_count_s), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
